// File: rtl/kernel3_gmem_a_m_axi_burst_split_pkg.sv
// Shared definitions for the gmem_A AXI master burst splitter: boundary size and FSM states.
package kernel3_gmem_A_m_axi_pkg;

   localparam int BOUNDARY_LOG2 = 12;

   typedef enum logic {
      IDLE  = 1'b0,
      SPLIT = 1'b1
   } split_state_t;

endpackage

// File: rtl/kernel3_gmem_a_m_axi_burst_split_calc.sv
// Combinational burst sizing: beats = min(remaining, max burst[, words to the next 4 KB line]).
// The 4 KB term is present only when GMEM_A_BURST_4K_SPLIT_EN is defined.
module kernel3_gmem_A_m_axi_burst_calc
   import kernel3_gmem_A_m_axi_pkg::*;
#(
   parameter int LEN_WIDTH      = 32,
   parameter int BYTES_LOG2     = 2,
   parameter int MAX_BURST_LOG2 = 4
) (
   input  logic [BOUNDARY_LOG2-1:0]  addr_low,
   input  logic [LEN_WIDTH-1:0]      remaining,
   output logic [MAX_BURST_LOG2:0]   beats,
   output logic [7:0]                len
);

   localparam int BEATS_W   = MAX_BURST_LOG2 + 1;
   localparam int BND_W     = BOUNDARY_LOG2 + 1;
   localparam int MAX_BURST = 1 << MAX_BURST_LOG2;

   logic [BEATS_W-1:0] cap;
   logic [BND_W-1:0]   to_bound;

   always_comb begin
      if (remaining < LEN_WIDTH'(MAX_BURST)) begin
         cap = remaining[BEATS_W-1:0];
      end else begin
         cap = BEATS_W'(MAX_BURST);
      end
   end

   // Words left before the next boundary line; never zero since addr_low < 4096.
   assign to_bound = ((BND_W'(1) << BOUNDARY_LOG2) - BND_W'(addr_low)) >> BYTES_LOG2;

`ifdef GMEM_A_BURST_4K_SPLIT_EN
   always_comb begin
      if (to_bound < BND_W'(cap)) begin
         beats = to_bound[BEATS_W-1:0];
      end else begin
         beats = cap;
      end
   end
`else
   logic unused_to_bound;
   assign unused_to_bound = ^to_bound;
   assign beats = cap;
`endif

   assign len = 8'(beats - BEATS_W'(1));

endmodule

// File: rtl/kernel3_gmem_a_m_axi_burst_split.sv
// Read-request burst splitter for the kernel3 gmem_A AXI master: one word-granular request in,
// a train of AXI-legal AR bursts out. Optional 4 KB splitting via GMEM_A_BURST_4K_SPLIT_EN.
module kernel3_gmem_a_m_axi_burst_split
   import kernel3_gmem_A_m_axi_pkg::*;
#(
   parameter int ADDR_WIDTH     = 64,
   parameter int LEN_WIDTH      = 32,
   parameter int BYTES_LOG2     = 2,
   parameter int MAX_BURST_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] in_addr,
   input  logic [LEN_WIDTH-1:0]  in_len,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [ADDR_WIDTH-1:0] out_addr,
   output logic [7:0]            out_len,
   output logic                  out_valid,
   input  logic                  out_ready
);

   split_state_t              state_reg, state_next;
   logic [ADDR_WIDTH-1:0]     cur_addr_reg, cur_addr_next;
   logic [LEN_WIDTH-1:0]      remaining_reg, remaining_next;
   logic [ADDR_WIDTH-1:0]     out_addr_reg;
   logic [7:0]                out_len_reg;
   logic                      out_valid_reg, in_ready_reg;

   logic                      load;
   logic [ADDR_WIDTH-1:0]     calc_addr;
   logic [LEN_WIDTH-1:0]      calc_rem;
   logic [MAX_BURST_LOG2:0]   calc_beats;
   logic [7:0]                calc_len;
   logic                      unused_in_addr;

   assign unused_in_addr = ^in_addr[BYTES_LOG2-1:0];

   // cur_addr/remaining already point past the burst sitting in the output register,
   // so in SPLIT the calculator sizes the next burst while the current one waits.
   always_comb begin
      if (state_reg == IDLE) begin
         calc_addr = {in_addr[ADDR_WIDTH-1:BYTES_LOG2], BYTES_LOG2'(0)};
         calc_rem  = in_len;
      end else begin
         calc_addr = cur_addr_reg;
         calc_rem  = remaining_reg;
      end
   end

   kernel3_gmem_A_m_axi_burst_calc #(
      .LEN_WIDTH      (LEN_WIDTH),
      .BYTES_LOG2     (BYTES_LOG2),
      .MAX_BURST_LOG2 (MAX_BURST_LOG2)
   ) u_calc (
      .addr_low  (calc_addr[BOUNDARY_LOG2-1:0]),
      .remaining (calc_rem),
      .beats     (calc_beats),
      .len       (calc_len)
   );

   always_comb begin
      state_next     = state_reg;
      load           = 1'b0;
      cur_addr_next  = calc_addr + (ADDR_WIDTH'(calc_beats) << BYTES_LOG2);
      remaining_next = calc_rem - LEN_WIDTH'(calc_beats);
      case (state_reg)
         IDLE: begin
            if (in_ready_reg && in_valid && (in_len != '0)) begin
               load       = 1'b1;
               state_next = SPLIT;
            end
         end
         SPLIT: begin
            if (out_ready) begin
               if (remaining_reg != '0) begin
                  load = 1'b1;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= IDLE;
         cur_addr_reg  <= '0;
         remaining_reg <= '0;
         out_addr_reg  <= '0;
         out_len_reg   <= '0;
         out_valid_reg <= 1'b0;
         in_ready_reg  <= 1'b0;
      end else begin
         state_reg     <= state_next;
         out_valid_reg <= (state_next == SPLIT);
         in_ready_reg  <= (state_next == IDLE);
         if (load) begin
            cur_addr_reg  <= cur_addr_next;
            remaining_reg <= remaining_next;
            out_addr_reg  <= calc_addr;
            out_len_reg   <= calc_len;
         end
      end
   end

   assign in_ready  = in_ready_reg;
   assign out_valid = out_valid_reg;
   assign out_addr  = out_addr_reg;
   assign out_len   = out_len_reg;

endmodule

// File: tb/tb_kernel3_gmem_a_m_axi_burst_split.sv
// Directed bench for the gmem_A burst splitter; expectations follow GMEM_A_BURST_4K_SPLIT_EN.
module tb_kernel3_gmem_a_m_axi_burst_split;

   logic        clk;
   logic        reset;
   logic [63:0] in_addr;
   logic [31:0] in_len;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] out_addr;
   logic [7:0]  out_len;
   logic        out_valid;
   logic        out_ready;

   int checks_cnt = 0;
   int errors_cnt = 0;

   kernel3_gmem_a_m_axi_burst_split dut (
      .clk       (clk),
      .reset     (reset),
      .in_addr   (in_addr),
      .in_len    (in_len),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_addr  (out_addr),
      .out_len   (out_len),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks_cnt++;
      if (got !== exp) begin
         errors_cnt++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for in_ready, then presents a request for one edge.
   task automatic send_req(input string tag, input logic [63:0] addr, input logic [31:0] len);
      for (int i = 0; i < 20 && !in_ready; i++) step();
      check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      in_addr  = addr;
      in_len   = len;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      $display("req %s: addr=0x%0h len=%0d", tag, addr, len);
   endtask

   // Checks the burst on the output this cycle, then advances one edge.
   task automatic expect_burst(input string tag, input logic [63:0] addr, input logic [7:0] len);
      check({tag, "_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_addr"}, out_addr, addr);
      check({tag, "_len"}, 64'(out_len), 64'(len));
      $display("burst %s: addr=0x%0h len=%0d", tag, out_addr, out_len);
      step();
   endtask

   task automatic expect_idle(input string tag);
      check({tag, "_idle_valid"}, 64'(out_valid), 64'd0);
      check({tag, "_idle_ready"}, 64'(in_ready), 64'd1);
   endtask

   initial begin
      reset     = 1'b1;
      in_addr   = '0;
      in_len    = '0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      step();
      step();
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_addr", out_addr, 64'd0);
      check("rst_len", 64'(out_len), 64'd0);
      reset = 1'b0;
      step();
      check("post_rst_in_ready", 64'(in_ready), 64'd1);

      out_ready = 1'b1;
      send_req("multi", 64'h1000, 32'd40);
      expect_burst("multi_b0", 64'h1000, 8'd15);
      expect_burst("multi_b1", 64'h1040, 8'd15);
      expect_burst("multi_b2", 64'h1080, 8'd7);
      expect_idle("multi");

      send_req("bound", 64'h0FF0, 32'd10);
`ifdef GMEM_A_BURST_4K_SPLIT_EN
      expect_burst("bound_b0", 64'h0FF0, 8'd3);
      expect_burst("bound_b1", 64'h1000, 8'd5);
`else
      expect_burst("bound_b0", 64'h0FF0, 8'd9);
`endif
      expect_idle("bound");

      send_req("zero", 64'h2000, 32'd0);
      expect_idle("zero");
      step();
      expect_idle("zero2");

      out_ready = 1'b0;
      send_req("bp", 64'h0, 32'd20);
      for (int i = 0; i < 5; i++) begin
         check("bp_hold_valid", 64'(out_valid), 64'd1);
         check("bp_hold_addr", out_addr, 64'h0);
         check("bp_hold_len", 64'(out_len), 64'd15);
         step();
      end
      out_ready = 1'b1;
      expect_burst("bp_b0", 64'h0, 8'd15);
      expect_burst("bp_b1", 64'h40, 8'd3);
      expect_idle("bp");

      send_req("unal", 64'h3003, 32'd1);
      expect_burst("unal_b0", 64'h3000, 8'd0);
      expect_idle("unal");

      send_req("rstmid", 64'h0, 32'd64);
      expect_burst("rstmid_b0", 64'h0, 8'd15);
      check("rstmid_b1_valid", 64'(out_valid), 64'd1);
      check("rstmid_b1_addr", out_addr, 64'h40);
      #2 reset = 1'b1;
      #1;
      check("rstmid_async_valid", 64'(out_valid), 64'd0);
      check("rstmid_async_in_ready", 64'(in_ready), 64'd0);
      check("rstmid_async_addr", out_addr, 64'd0);
      step();
      reset = 1'b0;
      check("rstmid_rel_in_ready", 64'(in_ready), 64'd0);
      step();
      check("rstmid_ready_after", 64'(in_ready), 64'd1);
      for (int i = 0; i < 4; i++) begin
         check("rstmid_no_burst", 64'(out_valid), 64'd0);
         step();
      end

      send_req("edge", 64'h0FFC, 32'd3);
`ifdef GMEM_A_BURST_4K_SPLIT_EN
      expect_burst("edge_b0", 64'h0FFC, 8'd0);
      expect_burst("edge_b1", 64'h1000, 8'd1);
`else
      expect_burst("edge_b0", 64'h0FFC, 8'd2);
`endif
      expect_idle("edge");

      $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
      $finish;
   end

endmodule
